// File: rtl/ss_score_ctrl.sv
// Score display controller: a binary score comes in over valid/ready and is
// converted to BCD one bit per clock. The digits are then scanned onto one
// seven-segment decoder, with optional blanking of leading zeros.
module ss_score_ctrl #(
   parameter int SCORE_W  = 8,
   parameter int NDIG     = 3,
   parameter int SCAN_DIV = 1000
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [SCORE_W-1:0] score_in,
   input  logic               score_valid,
   output logic               score_ready,
   input  logic               blank_lz,
   output logic [3:0]         digit_val,
   output logic               digit_en,
   output logic [NDIG-1:0]    digit_sel,
   output logic               busy
);

   localparam int ACC_W  = (NDIG + 1) * 4;
   localparam int CNT_W  = $clog2(SCORE_W + 1);
   localparam int SCAN_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int IDX_W  = (NDIG > 1) ? $clog2(NDIG) : 1;

   typedef enum logic [0:0] {IDLE, CONV} state_t;

   state_t               state, state_nxt;
   logic [SCORE_W-1:0]   shift, shift_nxt;
   logic [ACC_W-1:0]     acc, acc_adj, acc_nxt;
   logic                 ovf, ovf_nxt;
   logic [CNT_W-1:0]     bit_cnt;
   logic [NDIG*4-1:0]    disp, disp_nxt;
   logic [SCAN_W-1:0]    scan_cnt;
   logic [IDX_W-1:0]     scan_idx;
   logic                 upper_zero;

   // Handshake: a score is taken on any edge where score_valid and
   // score_ready are both high; score_valid seen while busy is dropped.
   assign score_ready = (state == IDLE);
   assign busy        = ~score_ready;

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: if (score_valid) state_nxt = CONV;
         CONV: if (bit_cnt == CNT_W'(1)) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // One double-dabble step: add 3 to each digit >= 5, then shift left.
   always_comb begin
      acc_adj = acc;
      for (int d = 0; d <= NDIG; d++) begin
         if (acc[d*4 +: 4] >= 4'd5) acc_adj[d*4 +: 4] = acc[d*4 +: 4] + 4'd3;
      end
      acc_nxt   = {acc_adj[ACC_W-2:0], shift[SCORE_W-1]};
      shift_nxt = shift << 1;
      // Bits pushed out of the accumulator top also count as overflow.
      ovf_nxt   = ovf | acc_adj[ACC_W-1];
      if (ovf_nxt || (acc_nxt[ACC_W-1 -: 4] != 4'd0)) disp_nxt = {NDIG{4'h9}};
      else                                            disp_nxt = acc_nxt[NDIG*4-1:0];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         shift   <= '0;
         acc     <= '0;
         ovf     <= 1'b0;
         bit_cnt <= '0;
         disp    <= '0;
      end else if (state == IDLE) begin
         if (score_valid) begin
            shift   <= score_in;
            acc     <= '0;
            ovf     <= 1'b0;
            bit_cnt <= CNT_W'(SCORE_W);
         end
      end else begin
         shift   <= shift_nxt;
         acc     <= acc_nxt;
         ovf     <= ovf_nxt;
         bit_cnt <= bit_cnt - 1'b1;
         if (bit_cnt == CNT_W'(1)) disp <= disp_nxt;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         scan_cnt <= '0;
         scan_idx <= '0;
      end else if (scan_cnt == SCAN_W'(SCAN_DIV - 1)) begin
         scan_cnt <= '0;
         scan_idx <= (scan_idx == IDX_W'(NDIG - 1)) ? '0 : scan_idx + 1'b1;
      end else begin
         scan_cnt <= scan_cnt + 1'b1;
      end
   end

   assign digit_sel = NDIG'(1) << scan_idx;

   // A digit is dark only if it and every digit above it are zero.
   always_comb begin
      digit_val  = 4'd0;
      upper_zero = 1'b1;
      for (int i = 0; i < NDIG; i++) begin
         if (scan_idx == IDX_W'(i)) digit_val = disp[i*4 +: 4];
         if ((i >= int'(scan_idx)) && (disp[i*4 +: 4] != 4'd0)) upper_zero = 1'b0;
      end
      digit_en = ~(blank_lz && (scan_idx != '0) && upper_zero);
   end

endmodule

// File: tb/tb_ss_score_ctrl.sv
// Bench for ss_score_ctrl: a 3-digit and a 2-digit instance with a short
// scan period, driven from a vector table plus hand-written sequences.
module tb_ss_score_ctrl;

   localparam int SCORE_W  = 8;
   localparam int NDIG     = 3;
   localparam int NDIG2    = 2;
   localparam int SCAN_DIV = 4;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic [SCORE_W-1:0] score_in, score_in2;
   logic               score_valid, score_valid2;
   logic               score_ready, score_ready2;
   logic               blank_lz, blank_lz2;
   logic [3:0]         digit_val, digit_val2;
   logic               digit_en, digit_en2;
   logic [NDIG-1:0]    digit_sel;
   logic [NDIG2-1:0]   digit_sel2;
   logic               busy, busy2;

   ss_score_ctrl #(.SCORE_W(SCORE_W), .NDIG(NDIG), .SCAN_DIV(SCAN_DIV)) dut (
      .clk(clk), .rst(rst), .score_in(score_in), .score_valid(score_valid),
      .score_ready(score_ready), .blank_lz(blank_lz), .digit_val(digit_val),
      .digit_en(digit_en), .digit_sel(digit_sel), .busy(busy)
   );

   ss_score_ctrl #(.SCORE_W(SCORE_W), .NDIG(NDIG2), .SCAN_DIV(SCAN_DIV)) dut2 (
      .clk(clk), .rst(rst), .score_in(score_in2), .score_valid(score_valid2),
      .score_ready(score_ready2), .blank_lz(blank_lz2), .digit_val(digit_val2),
      .digit_en(digit_en2), .digit_sel(digit_sel2), .busy(busy2)
   );

   // scan position reference: digit index advances every SCAN_DIV clocks
   int m_cnt, m_idx, m_idx2;
   always @(posedge clk) begin
      if (rst) begin
         m_cnt  <= 0;
         m_idx  <= 0;
         m_idx2 <= 0;
      end else if (m_cnt == SCAN_DIV - 1) begin
         m_cnt  <= 0;
         m_idx  <= (m_idx == NDIG - 1) ? 0 : m_idx + 1;
         m_idx2 <= (m_idx2 == NDIG2 - 1) ? 0 : m_idx2 + 1;
      end else begin
         m_cnt <= m_cnt + 1;
      end
   end

   typedef struct {
      logic [7:0] score;
      logic       blank;
      logic [3:0] d2, d1, d0;
      logic [2:0] en;
   } vec_t;

   vec_t vecs[8];
   int   n_cmp = 0;
   int   n_bad = 0;
   logic [3:0] cur_d [3];
   logic [3:0] cur_d2 [2];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic scan_check1(input string name, input logic [3:0] d2, input logic [3:0] d1,
                              input logic [3:0] d0, input logic [2:0] en);
      logic [3:0] ed [3];
      ed[0] = d0; ed[1] = d1; ed[2] = d2;
      for (int c = 0; c < NDIG * SCAN_DIV; c++) begin
         tick();
         chk({name, "_sel"}, 32'(digit_sel), 32'(3'b001 << m_idx));
         chk({name, "_val"}, 32'(digit_val), 32'(ed[m_idx]));
         chk({name, "_en"},  32'(digit_en),  32'(en[m_idx]));
      end
   endtask

   task automatic scan_check2(input string name, input logic [3:0] d1, input logic [3:0] d0,
                              input logic [1:0] en);
      logic [3:0] ed [2];
      ed[0] = d0; ed[1] = d1;
      for (int c = 0; c < NDIG2 * SCAN_DIV; c++) begin
         tick();
         chk({name, "_sel"}, 32'(digit_sel2), 32'(2'b01 << m_idx2));
         chk({name, "_val"}, 32'(digit_val2), 32'(ed[m_idx2]));
         chk({name, "_en"},  32'(digit_en2),  32'(en[m_idx2]));
      end
   endtask

   task automatic wait_ready1();
      int n = 0;
      while (!score_ready && n < 50) begin tick(); n++; end
      chk("ready1_wait", 32'(score_ready), 32'(1));
   endtask

   task automatic wait_ready2();
      int n = 0;
      while (!score_ready2 && n < 50) begin tick(); n++; end
      chk("ready2_wait", 32'(score_ready2), 32'(1));
   endtask

   // Pulse valid for one cycle; busy must last exactly SCORE_W cycles and
   // the old display must be shown throughout.
   task automatic send1(input logic [7:0] s);
      wait_ready1();
      score_in    = s;
      score_valid = 1'b1;
      tick();
      score_valid = 1'b0;
      for (int k = 0; k < SCORE_W; k++) begin
         chk("busy1", 32'(busy), 32'(1));
         chk("old_val1", 32'(digit_val), 32'(cur_d[m_idx]));
         tick();
      end
      chk("busy1_end", 32'(busy), 32'(0));
      chk("ready1_end", 32'(score_ready), 32'(1));
   endtask

   task automatic send2(input logic [7:0] s);
      wait_ready2();
      score_in2    = s;
      score_valid2 = 1'b1;
      tick();
      score_valid2 = 1'b0;
      for (int k = 0; k < SCORE_W; k++) begin
         chk("busy2", 32'(busy2), 32'(1));
         chk("old_val2", 32'(digit_val2), 32'(cur_d2[m_idx2]));
         tick();
      end
      chk("busy2_end", 32'(busy2), 32'(0));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      vecs[0] = '{8'd255, 1'b0, 4'd2, 4'd5, 4'd5, 3'b111};
      vecs[1] = '{8'd7,   1'b1, 4'd0, 4'd0, 4'd7, 3'b001};
      vecs[2] = '{8'd7,   1'b0, 4'd0, 4'd0, 4'd7, 3'b111};
      vecs[3] = '{8'd42,  1'b1, 4'd0, 4'd4, 4'd2, 3'b011};
      vecs[4] = '{8'd100, 1'b1, 4'd1, 4'd0, 4'd0, 3'b111};
      vecs[5] = '{8'd99,  1'b1, 4'd0, 4'd9, 4'd9, 3'b011};
      vecs[6] = '{8'd128, 1'b0, 4'd1, 4'd2, 4'd8, 3'b111};
      vecs[7] = '{8'd0,   1'b1, 4'd0, 4'd0, 4'd0, 3'b001};
      foreach (cur_d[i])  cur_d[i]  = 4'd0;
      foreach (cur_d2[i]) cur_d2[i] = 4'd0;

      score_in = '0;  score_valid = 1'b0;  blank_lz = 1'b0;
      score_in2 = '0; score_valid2 = 1'b0; blank_lz2 = 1'b0;
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;

      // reset state
      chk("rst_sel",   32'(digit_sel), 32'(1));
      chk("rst_val",   32'(digit_val), 32'(0));
      chk("rst_en",    32'(digit_en), 32'(1));
      chk("rst_ready", 32'(score_ready), 32'(1));
      chk("rst_busy",  32'(busy), 32'(0));
      blank_lz = 1'b1;
      #1 chk("rst_en_blank_digit0", 32'(digit_en), 32'(1));
      blank_lz = 1'b0;

      // table-driven conversions and scan
      for (int v = 0; v < 8; v++) begin
         blank_lz = vecs[v].blank;
         send1(vecs[v].score);
         cur_d[0] = vecs[v].d0; cur_d[1] = vecs[v].d1; cur_d[2] = vecs[v].d2;
         scan_check1($sformatf("vec%0d", v), vecs[v].d2, vecs[v].d1, vecs[v].d0, vecs[v].en);
      end

      // valid during busy ignored; held valid accepted when ready returns
      blank_lz = 1'b0;
      wait_ready1();
      score_in    = 8'd42;
      score_valid = 1'b1;
      tick();
      score_in = 8'd99;
      for (int k = 0; k < SCORE_W; k++) begin
         chk("t4_busy", 32'(busy), 32'(1));
         chk("t4_old_val", 32'(digit_val), 32'(cur_d[m_idx]));
         tick();
      end
      chk("t4_ready_back", 32'(score_ready), 32'(1));
      cur_d[0] = 4'd2; cur_d[1] = 4'd4; cur_d[2] = 4'd0;
      chk("t4_shows_042", 32'(digit_val), 32'(cur_d[m_idx]));
      tick();
      score_valid = 1'b0;
      for (int k = 0; k < SCORE_W; k++) begin
         chk("t4_busy99", 32'(busy), 32'(1));
         chk("t4_hold_042", 32'(digit_val), 32'(cur_d[m_idx]));
         tick();
      end
      chk("t4_busy99_end", 32'(busy), 32'(0));
      cur_d[0] = 4'd9; cur_d[1] = 4'd9; cur_d[2] = 4'd0;
      scan_check1("t4_099", 4'd0, 4'd9, 4'd9, 3'b111);

      // two-digit instance: overflow saturation and blanking
      blank_lz2 = 1'b1;
      send2(8'd123);
      cur_d2[0] = 4'd9; cur_d2[1] = 4'd9;
      scan_check2("t5_123", 4'd9, 4'd9, 2'b11);
      send2(8'd0);
      cur_d2[0] = 4'd0; cur_d2[1] = 4'd0;
      scan_check2("t5_0", 4'd0, 4'd0, 2'b01);
      blank_lz2 = 1'b0;
      send2(8'd99);
      cur_d2[0] = 4'd9; cur_d2[1] = 4'd9;
      scan_check2("t5_99", 4'd9, 4'd9, 2'b11);
      send2(8'd45);
      cur_d2[0] = 4'd5; cur_d2[1] = 4'd4;
      scan_check2("t5_45", 4'd4, 4'd5, 2'b11);
      send2(8'd100);
      cur_d2[0] = 4'd9; cur_d2[1] = 4'd9;
      scan_check2("t5_100", 4'd9, 4'd9, 2'b11);

      // reset on the 4th busy cycle aborts the conversion
      blank_lz = 1'b0;
      wait_ready1();
      score_in    = 8'd200;
      score_valid = 1'b1;
      tick();
      score_valid = 1'b0;
      tick();
      tick();
      tick();
      chk("t6_busy_before_rst", 32'(busy), 32'(1));
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("t6_busy",  32'(busy), 32'(0));
      chk("t6_ready", 32'(score_ready), 32'(1));
      chk("t6_sel",   32'(digit_sel), 32'(1));
      chk("t6_val",   32'(digit_val), 32'(0));
      chk("t6_en",    32'(digit_en), 32'(1));
      cur_d[0] = 4'd0; cur_d[1] = 4'd0; cur_d[2] = 4'd0;
      scan_check1("t6_zero_a", 4'd0, 4'd0, 4'd0, 3'b111);
      scan_check1("t6_zero_b", 4'd0, 4'd0, 4'd0, 3'b111);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
